// File: rtl/upct_param.sv
// upct_param: fully associative upper-PC table with tree pseudo-LRU replacement.
// Predictor entries keep a short target plus an index into this table. The
// update port finds or allocates an upper PC, and the read port expands an index
// back into the upper PC bits.
module upct_param #(
   parameter int UPCT_ENTRIES     = 8,
   parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
   parameter int UPPER_PC_WIDTH   = 21
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        read_valid_in,
   input  logic [LOG_UPCT_ENTRIES-1:0] read_index_in,
   output logic [UPPER_PC_WIDTH-1:0]   read_upper_PC_out,
   input  logic                        update_valid_in,
   input  logic [UPPER_PC_WIDTH-1:0]   update_upper_PC_in,
   output logic [LOG_UPCT_ENTRIES-1:0] update_index_out,
   output logic                        update_hit_out,
   input  logic                        flush_valid_in
);

   localparam int N = UPCT_ENTRIES;
   localparam int L = LOG_UPCT_ENTRIES;

   // Architectural state
   logic [UPPER_PC_WIDTH-1:0] pc_array [UPCT_ENTRIES];
   logic [N-1:0]              valid;
   logic [N-1:1]              plru;

   // State as seen after this cycle's flush has been applied
   logic [N-1:0]              valid_eff;
   logic [N-1:1]              plru_eff;

   // Lookup and allocation results
   logic [N-1:0]              match;
   logic [N-1:0]              victim_onehot;
   logic                      hit_found;
   logic                      have_invalid;
   logic                      write_en;
   logic [L-1:0]              hit_index;
   logic [L-1:0]              invalid_index;
   logic [L-1:0]              plru_index;
   logic [L-1:0]              alloc_index;
   logic [L-1:0]              upd_index;

   // Next-state values
   logic [N-1:0]              valid_next;
   logic [N-1:1]              plru_next;

   // A flush takes effect before any lookup in the same cycle, so it masks
   // the stored valid bits and PLRU tree rather than waiting for the edge.
   assign valid_eff = flush_valid_in ? '0 : valid;
   assign plru_eff  = flush_valid_in ? '0 : plru;

   // Per-entry tag compare and PLRU path check. An entry is the PLRU victim
   // when every node on its path from the root steers toward it.
   for (genvar e = 0; e < N; e++) begin : g_entry
      logic [L-1:0] path_ok;

      assign match[e] = valid_eff[e] && (pc_array[e] == update_upper_PC_in);

      for (genvar l = 0; l < L; l++) begin : g_level
         localparam int NODE = (e + N) >> (L - l);
         localparam int DIR  = (e >> (L - 1 - l)) & 1;
         assign path_ok[l] = (plru_eff[NODE] == DIR[0]);
      end

      assign victim_onehot[e] = &path_ok;
   end

   // Encode the hit entry, the lowest invalid entry and the PLRU victim.
   // Scanning downward lets the lowest matching index win.
   always_comb begin
      hit_index     = '0;
      invalid_index = '0;
      plru_index    = '0;
      have_invalid  = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_index = L'(i);
         end
         if (!valid_eff[i]) begin
            have_invalid  = 1'b1;
            invalid_index = L'(i);
         end
         if (victim_onehot[i]) begin
            plru_index = L'(i);
         end
      end
   end

   assign hit_found   = |match;
   assign alloc_index = have_invalid ? invalid_index : plru_index;
   assign upd_index   = hit_found ? hit_index : alloc_index;
   assign write_en    = update_valid_in && !hit_found;

   // A miss marks its allocated entry valid on top of the post-flush bits.
   always_comb begin
      valid_next = valid_eff;
      if (write_en) begin
         valid_next[alloc_index] = 1'b1;
      end
   end

   // PLRU tree update: each node on a touched entry's path is pointed away
   // from that entry. The update touch overrides the read touch on shared nodes.
   for (genvar l = 0; l < L; l++) begin : g_plru_level
      for (genvar k = 0; k < (1 << l); k++) begin : g_plru_node
         localparam int NODE = (1 << l) + k;
         logic read_on_path;
         logic update_on_path;

         assign read_on_path   = read_valid_in &&
                                 ((read_index_in >> (L - l)) == L'(k));
         assign update_on_path = update_valid_in &&
                                 ((upd_index >> (L - l)) == L'(k));
         assign plru_next[NODE] = update_on_path ? ~upd_index[L-1-l]     :
                                  read_on_path   ? ~read_index_in[L-1-l] :
                                                   plru_eff[NODE];
      end
   end

   // Table storage: contents survive a flush and are cleared only by reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < N; i++) begin
            pc_array[i] <= '0;
         end
      end else if (write_en) begin
         pc_array[alloc_index] <= update_upper_PC_in;
      end
   end

   // Valid bits and PLRU tree advance every cycle from their next-state values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= '0;
         plru  <= '0;
      end else begin
         valid <= valid_next;
         plru  <= plru_next;
      end
   end

   // Registered read data; the pre-write array value is returned on a
   // same-cycle read and replace, and the output holds while idle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         read_upper_PC_out <= '0;
      end else if (read_valid_in) begin
         read_upper_PC_out <= pc_array[read_index_in];
      end
   end

   // Registered update result; holds while no update is requested.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         update_index_out <= '0;
         update_hit_out   <= 1'b0;
      end else if (update_valid_in) begin
         update_index_out <= upd_index;
         update_hit_out   <= hit_found;
      end
   end

endmodule

// File: tb/tb_upct_param.sv
// tb_upct_param: directed bench for upct_param at depths 8, 2 and 16.
module tb_upct_param;

   logic        CLK;
   logic        nRST;

   // Depth-8 instance signals
   logic        rv8;
   logic [2:0]  ri8;
   logic [20:0] ro8;
   logic        uv8;
   logic [20:0] upc8;
   logic [2:0]  ui8;
   logic        uh8;
   logic        fl8;

   // Depth-2 instance signals
   logic        rv2;
   logic [0:0]  ri2;
   logic [20:0] ro2;
   logic        uv2;
   logic [20:0] upc2;
   logic [0:0]  ui2;
   logic        uh2;
   logic        fl2;

   // Depth-16 instance signals
   logic        rv16;
   logic [3:0]  ri16;
   logic [20:0] ro16;
   logic        uv16;
   logic [20:0] upc16;
   logic [3:0]  ui16;
   logic        uh16;
   logic        fl16;

   int checks;
   int errors;

   upct_param #(.UPCT_ENTRIES(8), .UPPER_PC_WIDTH(21)) dut8 (
      .CLK(CLK), .nRST(nRST),
      .read_valid_in(rv8), .read_index_in(ri8), .read_upper_PC_out(ro8),
      .update_valid_in(uv8), .update_upper_PC_in(upc8),
      .update_index_out(ui8), .update_hit_out(uh8),
      .flush_valid_in(fl8)
   );

   upct_param #(.UPCT_ENTRIES(2), .UPPER_PC_WIDTH(21)) dut2 (
      .CLK(CLK), .nRST(nRST),
      .read_valid_in(rv2), .read_index_in(ri2), .read_upper_PC_out(ro2),
      .update_valid_in(uv2), .update_upper_PC_in(upc2),
      .update_index_out(ui2), .update_hit_out(uh2),
      .flush_valid_in(fl2)
   );

   upct_param #(.UPCT_ENTRIES(16), .UPPER_PC_WIDTH(21)) dut16 (
      .CLK(CLK), .nRST(nRST),
      .read_valid_in(rv16), .read_index_in(ri16), .read_upper_PC_out(ro16),
      .update_valid_in(uv16), .update_upper_PC_in(upc16),
      .update_index_out(ui16), .update_hit_out(uh16),
      .flush_valid_in(fl16)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one request cycle into the selected instance, then return 1 time
   // unit after the edge with all request inputs idle again.
   task automatic applyStimulus(input int sel, input logic rv, input logic [3:0] ri,
                                input logic uv, input logic [20:0] upc,
                                input logic fl);
      case (sel)
         8: begin
            rv8 = rv; ri8 = ri[2:0]; uv8 = uv; upc8 = upc; fl8 = fl;
         end
         2: begin
            rv2 = rv; ri2 = ri[0:0]; uv2 = uv; upc2 = upc; fl2 = fl;
         end
         default: begin
            rv16 = rv; ri16 = ri; uv16 = uv; upc16 = upc; fl16 = fl;
         end
      endcase
      @(posedge CLK);
      #1;
      rv8  = 1'b0; uv8  = 1'b0; fl8  = 1'b0;
      rv2  = 1'b0; uv2  = 1'b0; fl2  = 1'b0;
      rv16 = 1'b0; uv16 = 1'b0; fl16 = 1'b0;
   endtask

   // Fill the depth-8 table from empty with values 1..8 into indices 0..7.
   task automatic fill8(input string tag);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'(i + 1), 1'b0);
         checkOutput(tag, 32'(ui8), i);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rv8  = 1'b0; ri8  = '0; uv8  = 1'b0; upc8  = '0; fl8  = 1'b0;
      rv2  = 1'b0; ri2  = '0; uv2  = 1'b0; upc2  = '0; fl2  = 1'b0;
      rv16 = 1'b0; ri16 = '0; uv16 = 1'b0; upc16 = '0; fl16 = 1'b0;

      // Reset values
      nRST = 1'b1;
      #1 nRST = 1'b0;
      #6;
      checkOutput("rst_read8", 32'(ro8), 32'h0);
      checkOutput("rst_index8", 32'(ui8), 32'h0);
      checkOutput("rst_hit8", 32'(uh8), 32'h0);
      #6 nRST = 1'b1;

      // Allocation from reset
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h12345, 1'b0);
      checkOutput("alloc_a_index", 32'(ui8), 0);
      checkOutput("alloc_a_hit", 32'(uh8), 0);
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h0ABCD, 1'b0);
      checkOutput("alloc_b_index", 32'(ui8), 1);
      checkOutput("alloc_b_hit", 32'(uh8), 0);
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h12345, 1'b0);
      checkOutput("rehit_a_index", 32'(ui8), 0);
      checkOutput("rehit_a_hit", 32'(uh8), 1);

      // PLRU victim after a full fill
      applyStimulus(8, 1'b0, 4'd0, 1'b0, 21'h0, 1'b1);
      fill8("fill_plru_index");
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h9, 1'b0);
      checkOutput("plru_victim_index", 32'(ui8), 0);
      checkOutput("plru_victim_hit", 32'(uh8), 0);

      // Read touch steers the victim to the other half
      applyStimulus(8, 1'b0, 4'd0, 1'b0, 21'h0, 1'b1);
      fill8("fill_touch_index");
      applyStimulus(8, 1'b1, 4'd0, 1'b0, 21'h0, 1'b0);
      checkOutput("touch_read0", 32'(ro8), 32'h1);
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h9, 1'b0);
      checkOutput("touch_victim_index", 32'(ui8), 4);
      checkOutput("touch_victim_hit", 32'(uh8), 0);
      // Back-to-back same value hits, and a read right after the write sees it
      applyStimulus(8, 1'b1, 4'd4, 1'b1, 21'h9, 1'b0);
      checkOutput("b2b_index", 32'(ui8), 4);
      checkOutput("b2b_hit", 32'(uh8), 1);
      checkOutput("read_after_write", 32'(ro8), 32'h9);

      // Flush together with an update
      applyStimulus(8, 1'b0, 4'd0, 1'b0, 21'h0, 1'b1);
      fill8("fill_flush_index");
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h5, 1'b1);
      checkOutput("flush_upd_index", 32'(ui8), 0);
      checkOutput("flush_upd_hit", 32'(uh8), 0);
      applyStimulus(8, 1'b1, 4'd0, 1'b0, 21'h0, 1'b0);
      checkOutput("flush_read0", 32'(ro8), 32'h5);
      applyStimulus(8, 1'b1, 4'd3, 1'b0, 21'h0, 1'b0);
      checkOutput("read_invalid_entry", 32'(ro8), 32'h4);
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h6, 1'b0);
      checkOutput("stale_no_hit_index", 32'(ui8), 1);
      checkOutput("stale_no_hit_hit", 32'(uh8), 0);

      // Same-cycle read and replace of index 0
      applyStimulus(8, 1'b0, 4'd0, 1'b0, 21'h0, 1'b1);
      fill8("fill_replace_index");
      applyStimulus(8, 1'b1, 4'd0, 1'b1, 21'h9, 1'b0);
      checkOutput("replace_read_old", 32'(ro8), 32'h1);
      checkOutput("replace_index", 32'(ui8), 0);
      checkOutput("replace_hit", 32'(uh8), 0);
      applyStimulus(8, 1'b1, 4'd0, 1'b0, 21'h0, 1'b0);
      checkOutput("replace_read_new", 32'(ro8), 32'h9);
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h1, 1'b0);
      checkOutput("evicted_realloc_index", 32'(ui8), 4);
      checkOutput("evicted_realloc_hit", 32'(uh8), 0);
      // Outputs hold across an idle cycle
      applyStimulus(8, 1'b0, 4'd0, 1'b0, 21'h0, 1'b0);
      checkOutput("hold_read", 32'(ro8), 32'h9);
      checkOutput("hold_index", 32'(ui8), 4);
      applyStimulus(8, 1'b0, 4'd0, 1'b1, 21'h1, 1'b0);
      checkOutput("realloc_rehit_index", 32'(ui8), 4);
      checkOutput("realloc_rehit_hit", 32'(uh8), 1);

      // Depth 2
      applyStimulus(2, 1'b0, 4'd0, 1'b1, 21'hA, 1'b0);
      checkOutput("n2_fill0", 32'(ui2), 0);
      applyStimulus(2, 1'b0, 4'd0, 1'b1, 21'hB, 1'b0);
      checkOutput("n2_fill1", 32'(ui2), 1);
      applyStimulus(2, 1'b0, 4'd0, 1'b1, 21'hC, 1'b0);
      checkOutput("n2_victim_index", 32'(ui2), 0);
      checkOutput("n2_victim_hit", 32'(uh2), 0);
      applyStimulus(2, 1'b1, 4'd1, 1'b0, 21'h0, 1'b0);
      checkOutput("n2_read1", 32'(ro2), 32'hB);

      // Depth 16
      for (int i = 0; i < 16; i++) begin
         applyStimulus(16, 1'b0, 4'd0, 1'b1, 21'(i + 1), 1'b0);
         checkOutput("n16_fill_index", 32'(ui16), i);
      end
      applyStimulus(16, 1'b0, 4'd0, 1'b1, 21'h11, 1'b0);
      checkOutput("n16_victim0_index", 32'(ui16), 0);
      checkOutput("n16_victim0_hit", 32'(uh16), 0);
      applyStimulus(16, 1'b0, 4'd0, 1'b1, 21'h12, 1'b0);
      checkOutput("n16_victim8_index", 32'(ui16), 8);

      // Asynchronous reset in the middle of a request
      uv16  = 1'b1;
      upc16 = 21'h77;
      #2 nRST = 1'b0;
      #1;
      checkOutput("mid_rst_index16", 32'(ui16), 0);
      checkOutput("mid_rst_read8", 32'(ro8), 0);
      checkOutput("mid_rst_index8", 32'(ui8), 0);
      checkOutput("mid_rst_hit8", 32'(uh8), 0);
      checkOutput("mid_rst_read2", 32'(ro2), 0);
      @(posedge CLK);
      #1;
      checkOutput("mid_rst_held_index16", 32'(ui16), 0);
      uv16 = 1'b0;
      #2 nRST = 1'b1;
      applyStimulus(16, 1'b1, 4'd0, 1'b1, 21'h5, 1'b0);
      checkOutput("post_rst_read16", 32'(ro16), 0);
      checkOutput("post_rst_index16", 32'(ui16), 0);
      checkOutput("post_rst_hit16", 32'(uh16), 0);
      applyStimulus(16, 1'b1, 4'd0, 1'b0, 21'h0, 1'b0);
      checkOutput("post_rst_read_new16", 32'(ro16), 32'h5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/upct_param.md
# upct_param

Parametrised upper-PC table (UPCT): an N-entry, fully associative store of upper PC bits, replaced by tree pseudo-LRU. It lets BTB and RAS entries keep only a short target plus a UPCT index. It sits beside the fetch predictors: decode/resolve allocates upper PCs through the update port, and fetch expands predicted targets through the read port. This generation replaces the fixed 8-entry table with any power-of-two depth, adds per-entry valid bits, and adds a single-cycle flush.

## Interface
- UPCT_ENTRIES, 8, entry count; power of two, at least 2
- LOG_UPCT_ENTRIES, $clog2(UPCT_ENTRIES), index width
- UPPER_PC_WIDTH, 21, stored upper PC width (32 - BTB_TARGET_WIDTH - 1)
- CLK  in  1  clock; single clock domain, all state on rising edge
- nRST  in  1  reset, asynchronous assert, active-low
- read_valid_in  in  1  read request this cycle
- read_index_in  in  LOG_UPCT_ENTRIES  entry to read
- read_upper_PC_out  out  UPPER_PC_WIDTH  registered read data
- update_valid_in  in  1  lookup/allocate request
- update_upper_PC_in  in  UPPER_PC_WIDTH  upper PC to find or insert
- update_index_out  out  LOG_UPCT_ENTRIES  registered index holding update_upper_PC_in
- update_hit_out  out  1  registered; 1 if the value was already present and valid
- flush_valid_in  in  1  invalidate all entries and reset PLRU

## Operation
- State:
  - array[UPCT_ENTRIES] of UPPER_PC_WIDTH
  - valid[UPCT_ENTRIES]
  - plru: UPCT_ENTRIES-1 bits in heap order; node 1 is the root, children of node k are 2k and 2k+1
- PLRU convention:
  - Node bit 0 steers the victim search to the lower-index half; bit 1 steers it to the upper half.
  - Touching entry e sets every node on e's path to point away from e.
- Read:
  - On read_valid_in, the array is read at read_index_in. The data is returned whether or not the entry is valid.
  - The read touches PLRU for read_index_in.
- Update:
  - Compare update_upper_PC_in against all valid entries. At most one can match, by construction.
  - On a hit, return the matching index with hit=1 and touch it.
  - On a miss, pick a victim: the lowest-index invalid entry if one exists, else the PLRU victim. Write the value, set valid, touch the victim, and return its index with hit=0.
- Flush: clears all valid bits and sets plru to all zeros. Array contents are retained.
- Simultaneous events, applied in this order within one cycle:
  1. flush
  2. read touch
  3. update hit check, allocate and touch

  Consequences:
  - Update with flush: compares against all-invalid, allocates entry 0, hit=0.
  - Read with update on the same index: read data is the pre-write array value.
  - Read touch and update touch in the same cycle: nodes touched by both take the update value.
- No stall or backpressure; every request is accepted every cycle.
- While no read is issued, the read output holds its value; likewise the update outputs.

## Timing
- Read latency is 1 cycle: read_upper_PC_out is valid the cycle after read_valid_in.
- Update latency is 1 cycle: update_index_out and update_hit_out are valid the cycle after update_valid_in. The array, valid and plru are updated at the same edge.
- Back-to-back updates of the same new value: the second cycle sees the first write and hits.
- A read issued the cycle after an update to that index returns the new value.
- Reset (nRST low, asynchronous):
  - valid = 0, plru = 0, array = 0
  - read_upper_PC_out = 0, update_index_out = 0, update_hit_out = 0
- Reset mid-operation: any in-flight request is discarded, and outputs show reset values until the next request completes.

## Test plan
- Allocation from reset (N=8):
  - update 0x12345 -> index 0, hit 0
  - update 0x0ABCD -> index 1, hit 0
  - update 0x12345 -> index 0, hit 1
- PLRU victim after a full fill (N=8): allocate values 0x1..0x8 into indices 0..7, then update 0x9 -> index 0, hit 0.
- Read touch: same fill, then read index 0 -> 0x1 next cycle; then update 0x9 -> index 4, hit 0.
- Flush with update: fill 8 entries, then flush plus update 0x5 (previously at index 4) in the same cycle -> index 0, hit 0; read index 0 -> 0x5.
- Same-cycle read and replace: full table, then read index 0 plus update 0x9 (victim 0) -> read returns 0x1, update index 0; the next read of index 0 returns 0x9.
- Parameter sweep, N=2 and N=16: fill sequentially, then one new value -> index 0. For N=16, touch 0 then allocate -> index 8. Asserting nRST mid-sequence zeroes all outputs asynchronously.
